// File: rtl/module_alu_sequencer.sv
// Multi-precision sequencer: runs a WORDS*N-bit add/sub/and/or through an external N-bit ALU, one slice per cycle, LS slice first.
// Latency: WORDS+1 cycles from accepted start to done_o. An unsupported opcode completes in 1 cycle with err_o set.
// Backpressure: ready_o gates start_i. It is high in IDLE, and also in DONE when ALU_SEQ_BACK2BACK_EN is defined.
//
// Ports:
//   clk_i, rst_n_i            : clock (rising edge), asynchronous active-low reset
//   start_i / ready_o         : command handshake; op_i, a_i, b_i, carry_in_i are sampled on acceptance
//   alu_a_o, alu_b_o,
//   alu_flag_o, alu_ctrl_o    : drive the ALU slice inputs while executing, 0 otherwise
//   alu_result_i, alu_carry_i,
//   alu_zero_i                : ALU slice outputs
//   result_o, carry_o,
//   zero_o, err_o             : final results, held until the next accepted command
//   done_o                    : one-cycle completion pulse
//
// Optional feature macro: ALU_SEQ_BACK2BACK_EN. It allows accepting a new command in DONE, which removes the idle bubble.

module module_alu_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic [3:0]           op_i,
  input  logic [N*WORDS-1:0]   a_i,
  input  logic [N*WORDS-1:0]   b_i,
  input  logic                 carry_in_i,
  output logic [N-1:0]         alu_a_o,
  output logic [N-1:0]         alu_b_o,
  output logic                 alu_flag_o,
  output logic [3:0]           alu_ctrl_o,
  input  logic [N-1:0]         alu_result_i,
  input  logic                 alu_carry_i,
  input  logic                 alu_zero_i,
  output logic [N*WORDS-1:0]   result_o,
  output logic                 carry_o,
  output logic                 zero_o,
  output logic                 err_o,
  output logic                 done_o
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  localparam logic [3:0] OP_OR  = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  res_q, res_next;
  logic [IW-1:0] idx_q;
  logic          flag_q;
  logic          zacc_q;
  logic          accept;
  logic          op_in_valid;
  logic          op_in_arith;
  logic          op_q_arith;
  logic          flag_next;

  // The four supported opcodes are exactly those with the top two bits clear.
  // Bit 1 then separates add/sub (carry chained) from and/or (no carry).
  assign op_in_valid = (op_i[3:2] == 2'b00);
  assign op_in_arith = op_in_valid && (op_i == OP_ADD || op_i == OP_SUB);
  assign op_q_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign flag_next   = op_q_arith ? alu_carry_i : 1'b0;

  // Result image with the current slice merged in. On the final slice, result_o is loaded from this value.
  always_comb begin
    res_next = res_q;
    res_next[idx_q*N +: N] = alu_result_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake and ALU drive
  always_comb begin
    state_d    = state_q;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    accept     = 1'b0;
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_flag_o = 1'b0;
    alu_ctrl_o = 4'b0000;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          accept  = 1'b1;
          state_d = op_in_valid ? EXEC : DONE;
        end
      end
      EXEC: begin
        alu_a_o    = a_q[idx_q*N +: N];
        alu_b_o    = b_q[idx_q*N +: N];
        alu_flag_o = flag_q;
        alu_ctrl_o = op_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
`ifdef ALU_SEQ_BACK2BACK_EN
        ready_o = 1'b1;
        if (start_i) begin
          accept  = 1'b1;
          state_d = op_in_valid ? EXEC : DONE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: operand latch, slice accumulation and final result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q     <= 4'b0000;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      flag_q   <= 1'b0;
      zacc_q   <= 1'b0;
      result_o <= '0;
      carry_o  <= 1'b0;
      zero_o   <= 1'b0;
      err_o    <= 1'b0;
    end else if (accept) begin
      op_q   <= op_i;
      a_q    <= a_i;
      b_q    <= b_i;
      res_q  <= '0;
      idx_q  <= '0;
      flag_q <= op_in_arith ? carry_in_i : 1'b0;
      zacc_q <= 1'b1;
      // A bad opcode finishes here. The outputs are published now because no EXEC pass will follow.
      if (!op_in_valid) begin
        err_o    <= 1'b1;
        result_o <= '0;
        carry_o  <= 1'b0;
        zero_o   <= 1'b1;
      end
    end else if (state_q == EXEC) begin
      res_q  <= res_next;
      flag_q <= flag_next;
      zacc_q <= zacc_q & alu_zero_i;
      if (idx_q == LAST_IDX) begin
        idx_q    <= '0;
        result_o <= res_next;
        carry_o  <= flag_next;
        zero_o   <= zacc_q & alu_zero_i;
        err_o    <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule
